systolic_result_drain: RTL
==========================

Name: systolic_result_drain

Overview:
- Sits at the bottom edge of the DTPU systolic array and receives the partial-sum results leaving the last row of smac cells.
- Columns emit results skewed by one cycle per column. This block delays each column so that one full output row lines up, then buffers complete rows in a small FIFO.
- It presents those rows to the result writer over a valid/ready handshake, with a last marker every ROWS words.

Parameters:
- COLS, 8, number of array columns.
- DATA_W, 64, width of one column result (bit_width*bit_width).
- FIFO_DEPTH, 4, number of aligned rows buffered; power of two, at least 2.
- ROWS, 8, words per output tile; out_last marks every ROWS-th popped word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  array advance enable; the deskew lines shift only when ce=1.
- col_data  in  COLS*DATA_W  column results; column c occupies bits [(c+1)*DATA_W-1 : c*DATA_W].
- col_valid  in  COLS  per-column result valid.
- clr_flags  in  1  synchronous clear of the sticky error flags.
- out_data  out  COLS*DATA_W  aligned row, same column packing as col_data.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accept.
- out_last  out  1  current out_data is the last word of a tile.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- skew_err  out  1  sticky: the aligned valids disagreed.
- overflow  out  1  sticky: an aligned row was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, any time including mid-transfer) clears:
  - all delay registers;
  - FIFO pointers and fifo_count;
  - the pop counter;
  - skew_err and overflow.
  - Outputs after reset: out_valid=0, out_last=0, out_data=0, fifo_count=0.
- Deskew:
  - Column c passes data and valid through COLS-1-c registers, all enabled by ce.
  - Column COLS-1 has no delay.
  - With ce=0 the registers hold their contents and no FIFO write occurs.
- Alignment: at a rising edge with ce=1, take av = {delayed valids of columns 0..COLS-2, col_valid[COLS-1]}.
  - av all ones: write the aligned row into the FIFO.
  - av mixed: no write, and skew_err is set.
  - av all zeros: no action.
- Latency: a row whose column c was sampled at edge E-(COLS-1-c) is written at edge E. out_valid is high after E if the FIFO was empty, so there is no combinational bypass.
- FIFO:
  - Pop when out_valid & out_ready.
  - out_data is the head entry, driven from a register or memory and held stable while out_valid=1 and out_ready=0.
- FIFO boundary cases:
  - Push with pop while full: both happen and count is unchanged.
  - Push while full with no pop: the row is dropped and overflow is set.
  - Push with pop while empty: only the push happens; the pop is not legal because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Tile counter:
  - Increments on each pop and wraps to 0 after ROWS-1.
  - out_last = out_valid & (counter == ROWS-1).
  - Dropped rows do not advance the counter.
- Sticky flags:
  - clr_flags=1 clears skew_err and overflow at the next edge.
  - A set event in the same cycle as clr_flags wins, so the flag stays 1.
- Arithmetic and transforms: data passes through unmodified. There is no arithmetic, no sign extension and no reordering of columns.

Test Plan:
- Aligned row (COLS=4, DATA_W=16): drive column c with data 0x1000+c and valid at cycle t+c, all with ce=1 and out_ready=1. Required: out_valid rises 1 cycle after t+3, out_data=0x1003_1002_1001_1000, fifo_count returns to 0 after the pop.
- Stall mid-skew: same stimulus with ce=0 for 2 cycles after t+1, and each remaining column's valid pushed back 2 cycles. Required: identical row delivered, no skew_err, 2-cycle later arrival.
- Backpressure and overflow: out_ready=0 and 5 aligned rows with FIFO_DEPTH=4. Required:
  - fifo_count=4 and overflow=1;
  - raising out_ready then yields rows 1..4 in order, and row 5 is absent.
- Full with simultaneous push/pop: FIFO full and out_ready=1 while a new aligned row arrives. Required: count stays 4, no overflow, order preserved.
- Skew error and clear: assert only col_valid[0] at t. Required:
  - skew_err=1 at edge t+3, no write;
  - clr_flags pulse clears it;
  - clr_flags coincident with a new mismatch leaves it at 1.
- Tile last and reset: pop 10 rows with ROWS=8. Required:
  - out_last high on pops 8 only (counter wraps, pop 10 is index 1);
  - asserting reset while 2 rows are buffered drops out_valid immediately, with fifo_count=0 and all flags 0.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Deskews the bottom-row column results of the systolic array and buffers
// aligned rows in a small FIFO drained over a valid/ready handshake.
module systolic_result_drain #(
    parameter int COLS       = 8,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic [COLS*DATA_W-1:0]         col_data,
    input  logic [COLS-1:0]                col_valid,
    input  logic                           clr_flags,
    output logic [COLS*DATA_W-1:0]         out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           skew_err,
    output logic                           overflow
);

    localparam int W  = COLS * DATA_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(ROWS - 1);

    logic [W-1:0]    al_data;
    logic [COLS-1:0] av;

    // Column c is delayed COLS-1-c ce-gated stages so all columns meet
    // at the same edge; the rightmost column feeds straight through.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_col
        localparam int D = COLS - 1 - c;

        logic [DATA_W-1:0] dd_q [D];
        logic [DATA_W-1:0] dd_d [D];
        logic [D-1:0]      dv_q;
        logic [D-1:0]      dv_d;

        always_comb begin
            dd_d = dd_q;
            dv_d = dv_q;
            if (ce) begin
                dd_d[0] = col_data[c*DATA_W +: DATA_W];
                dv_d[0] = col_valid[c];
                for (int k = 1; k < D; k++) begin
                    dd_d[k] = dd_q[k-1];
                    dv_d[k] = dv_q[k-1];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dd_q <= '{default: '0};
                dv_q <= '0;
            end else begin
                dd_q <= dd_d;
                dv_q <= dv_d;
            end
        end

        assign al_data[c*DATA_W +: DATA_W] = dd_q[D-1];
        assign av[c]                       = dv_q[D-1];
    end

    assign al_data[(COLS-1)*DATA_W +: DATA_W] =
        col_data[(COLS-1)*DATA_W +: DATA_W];
    assign av[COLS-1] = col_valid[COLS-1];

    logic row_push;
    logic row_skew;

    assign row_push = ce & (&av);
    assign row_skew = ce & (|av) & ~(&av);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [W-1:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] tile_q, tile_d;
    logic          skew_q, skew_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic pop;
    logic wr_en;
    logic drop;

    assign full  = (cnt_q == FULL_CNT);
    assign pop   = out_valid & out_ready;
    // A full FIFO still accepts a row when the head leaves the same cycle.
    assign wr_en = row_push & (~full | pop);
    assign drop  = row_push & full & ~pop;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        tile_d = tile_q;

        if (wr_en) begin
            mem_d[wptr_q] = al_data;
            wptr_d        = wptr_q + 1'b1;
        end

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            tile_d = (tile_q == LAST_IDX) ? '0 : tile_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Set events override a coincident clear.
    always_comb begin
        skew_d = clr_flags ? 1'b0 : skew_q;
        ovf_d  = clr_flags ? 1'b0 : ovf_q;
        if (row_skew) begin
            skew_d = 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            tile_q <= '0;
            skew_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            tile_q <= tile_d;
            skew_q <= skew_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid  = (cnt_q != '0);
    assign out_data   = mem_q[rptr_q];
    assign out_last   = out_valid & (tile_q == LAST_IDX);
    assign fifo_count = cnt_q;
    assign skew_err   = skew_q;
    assign overflow   = ovf_q;

endmodule
